// File: rtl/fetch_stage_if_id.sv
// fetch_stage_if_id: PC register, imem request/ack port and IF/ID register.
// Optional macro PERF_CNT_EN adds fetch_cnt / stall_cnt counters.
module fetch_stage_if_id #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCOUT,
  output logic [31:0] INST_IF_ID,
  output logic [31:0] PCIN_IF_ID,
  output logic        valid_IF_ID
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_KILL
  } state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pcin;
    logic        valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{
    inst:  NOP_INST,
    pcin:  32'h0,
    valid: 1'b0
  };

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_hold_inst;
  logic [31:0] w_hold_nxt;
  logic [31:0] r_pend_target;
  logic [31:0] w_pend_nxt;
  if_id_t      r_ifid;
  if_id_t      w_ifid_nxt;
  logic [31:0] w_tgt;
  logic [31:0] w_pc_inc;
  logic        w_req;

  logic w_br_ack;
  logic w_br_wait;
  logic w_take;
  logic w_park;
  logic w_wait_stall;
  logic w_wait;

  assign w_tgt    = branch_target & 32'hFFFF_FFFC;
  assign w_pc_inc = r_pc + 32'd4;

  assign w_br_ack     = branch_taken & imem_ack;
  assign w_br_wait    = branch_taken & ~imem_ack;
  assign w_take       = ~branch_taken & imem_ack & ~stall;
  assign w_park       = ~branch_taken & imem_ack & stall;
  assign w_wait_stall = ~branch_taken & ~imem_ack & stall;
  assign w_wait       = ~branch_taken & ~imem_ack & ~stall;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // next-state: leave FETCH only to park a word or chase a branch
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (w_br_wait)   w_state_nxt = S_KILL;
        else if (w_park) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (branch_taken || !stall)
          w_state_nxt = S_FETCH;
      end
      S_KILL: begin
        if (imem_ack) w_state_nxt = S_FETCH;
      end
    endcase
  end

  // outputs: request strobe and next PC / IF/ID / side registers
  always_comb begin
    w_req      = 1'b0;
    w_pc_nxt   = r_pc;
    w_ifid_nxt = r_ifid;
    w_hold_nxt = r_hold_inst;
    w_pend_nxt = r_pend_target;
    unique case (r_state)
      S_IDLE: begin
      end
      S_FETCH: begin
        w_req = 1'b1;
        unique case (1'b1)
          w_br_ack: begin
            w_pc_nxt   = w_tgt;
            w_ifid_nxt = BUBBLE;
          end
          w_br_wait: begin
            w_pend_nxt = w_tgt;
            w_ifid_nxt = BUBBLE;
          end
          w_take: begin
            w_ifid_nxt = '{imem_rdata, w_pc_inc, 1'b1};
            w_pc_nxt   = w_pc_inc;
          end
          w_park: begin
            w_hold_nxt = imem_rdata;
          end
          w_wait_stall: begin
          end
          w_wait: begin
            w_ifid_nxt = BUBBLE;
          end
        endcase
      end
      S_HOLD: begin
        if (branch_taken) begin
          w_pc_nxt   = w_tgt;
          w_ifid_nxt = BUBBLE;
          w_hold_nxt = 32'h0;
        end else if (!stall) begin
          w_ifid_nxt = '{r_hold_inst, w_pc_inc, 1'b1};
          w_pc_nxt   = w_pc_inc;
        end
      end
      S_KILL: begin
        w_req      = 1'b1;
        w_ifid_nxt = BUBBLE;
        if (branch_taken) w_pend_nxt = w_tgt;
        if (imem_ack)
          w_pc_nxt = branch_taken ? w_tgt : r_pend_target;
      end
    endcase
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_ifid        <= BUBBLE;
      r_hold_inst   <= 32'h0;
      r_pend_target <= 32'h0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_ifid        <= w_ifid_nxt;
      r_hold_inst   <= w_hold_nxt;
      r_pend_target <= w_pend_nxt;
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign PCOUT       = r_pc;
  assign INST_IF_ID  = r_ifid.inst;
  assign PCIN_IF_ID  = r_ifid.pcin;
  assign valid_IF_ID = r_ifid.valid;

`ifdef PERF_CNT_EN
  logic        w_load;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  assign w_load = (r_state == S_FETCH && w_take)
               || (r_state == S_HOLD
                   && !branch_taken && !stall);

  // count valid IF/ID loads and non-flushed stall edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt <= 32'h0;
      r_stall_cnt <= 32'h0;
    end else begin
      if (w_load)
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (stall && !branch_taken)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage_if_id.sv
// tb_fetch_stage_if_id: random + directed stimulus vs a transaction model.
// Builds with or without PERF_CNT_EN.
module tb_fetch_stage_if_id;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] PCOUT;
  logic [31:0] INST_IF_ID;
  logic [31:0] PCIN_IF_ID;
  logic        valid_IF_ID;
`ifdef PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_stage_if_id #(
    .RESET_PC(32'h0),
    .NOP_INST(NOP)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .PCOUT        (PCOUT),
    .INST_IF_ID   (INST_IF_ID),
    .PCIN_IF_ID   (PCIN_IF_ID),
    .valid_IF_ID  (valid_IF_ID)
`ifdef PERF_CNT_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // transaction-level model: started, parked word, kill pending
  bit          m_up;
  bit          m_hold;
  bit          m_kill;
  logic [31:0] m_pc;
  logic [31:0] m_hbuf;
  logic [31:0] m_tgt;
  logic [31:0] m_inst;
  logic [31:0] m_pcin;
  bit          m_val;
  logic [31:0] m_fcnt;
  logic [31:0] m_scnt;

  // memory: ack after lat waiting cycles of one request
  int lat = 0;
  int m_wait = 0;
  bit force_ack = 1'b0;

  function automatic void model_reset();
    m_up = 0; m_hold = 0; m_kill = 0;
    m_pc = 32'h0; m_hbuf = 32'h0; m_tgt = 32'h0;
    m_inst = NOP; m_pcin = 32'h0; m_val = 0;
    m_fcnt = 32'h0; m_scnt = 32'h0;
  endfunction

  function automatic void bubble();
    m_inst = NOP; m_pcin = 32'h0; m_val = 0;
  endfunction

  function automatic void model_edge(bit st, bit bt,
      logic [31:0] tg, bit ack, logic [31:0] rd);
    logic [31:0] t;
    logic [31:0] w;
    bit have;
    t = tg & 32'hFFFF_FFFC;
    if (st && !bt) m_scnt = m_scnt + 1;
    if (!m_up) begin
      m_up = 1;
      return;
    end
    if (m_kill) begin
      if (bt) m_tgt = t;
      if (ack) begin
        m_pc = m_tgt;
        m_kill = 0;
      end
      bubble();
    end else if (bt) begin
      bubble();
      if (!m_hold && !ack) begin
        m_kill = 1;
        m_tgt = t;
      end else begin
        m_pc = t;
      end
      m_hold = 0;
    end else begin
      have = m_hold || ack;
      w = m_hold ? m_hbuf : rd;
      if (!have) begin
        if (!st) bubble();
      end else if (st) begin
        if (!m_hold) begin
          m_hold = 1;
          m_hbuf = w;
        end
      end else begin
        m_inst = w;
        m_pcin = m_pc + 32'd4;
        m_val = 1;
        m_pc = m_pc + 32'd4;
        m_hold = 0;
        m_fcnt = m_fcnt + 1;
      end
    end
  endfunction

  task automatic check_all();
    check("req", {31'h0, imem_req}, {31'h0, m_up && !m_hold});
    check("addr", imem_addr, m_pc);
    check("pc", PCOUT, m_pc);
    check("inst", INST_IF_ID, m_inst);
    check("pcin", PCIN_IF_ID, m_pcin);
    check("valid", {31'h0, valid_IF_ID}, {31'h0, m_val});
`ifdef PERF_CNT_EN
    check("fcnt", fetch_cnt, m_fcnt);
    check("scnt", stall_cnt, m_scnt);
`endif
  endtask

  // one cycle: check at negedge, drive, clock, advance model
  task automatic step(bit st, bit bt, logic [31:0] tg);
    bit rq;
    bit ack;
    logic [31:0] rd;
    check_all();
    rq = m_up && !m_hold;
    ack = force_ack || (rq && m_wait >= lat);
    rd = m_pc + 32'h1000;
    stall = st;
    branch_taken = bt;
    branch_target = tg;
    imem_ack = ack;
    imem_rdata = rd;
    @(posedge clk);
    model_edge(st, bt, tg, ack, rd);
    if (rq && !ack) m_wait++;
    else m_wait = 0;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    imem_ack = force_ack;
    #1;
    model_reset();
    m_wait = 0;
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    reset_dut();

    // zero-wait streaming
    lat = 0;
    repeat (6) step(0, 0, 32'h0);

    // two-cycle ack delay
    lat = 2;
    repeat (9) step(0, 0, 32'h0);

    // stall coincident with ack at PC=8
    lat = 0;
    reset_dut();
    repeat (3) step(0, 0, 32'h0);
    repeat (3) step(1, 0, 32'h0);
    repeat (2) step(0, 0, 32'h0);

    // branch while ack for 0x10 still pending
    reset_dut();
    repeat (5) step(0, 0, 32'h0);
    lat = 2;
    step(0, 1, 32'h40);
    repeat (2) step(0, 0, 32'h0);
    repeat (3) step(0, 0, 32'h0);

    // branch overrides stall, low bits masked
    lat = 0;
    step(1, 1, 32'h23);
    repeat (2) step(0, 0, 32'h0);

    // PC wrap at top of address space
    step(0, 1, 32'hFFFF_FFFC);
    repeat (3) step(0, 0, 32'h0);

    // reset mid-fetch with stray acks
    lat = 3;
    repeat (2) step(0, 0, 32'h0);
    force_ack = 1'b1;
    reset_dut();
    step(0, 0, 32'h0);
    force_ack = 1'b0;
    repeat (6) step(0, 0, 32'h0);

    // randomized phases
    for (int p = 0; p < 8; p++) begin
      int sp;
      int bp;
      lat = $urandom_range(0, 3);
      sp = $urandom_range(0, 50);
      bp = $urandom_range(0, 25);
      for (int i = 0; i < 250; i++) begin
        step($urandom_range(0, 99) < sp,
             $urandom_range(0, 99) < bp,
             $urandom);
      end
    end
    check_all();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
